// File: rtl/trig_dist_pkg.sv
// Shared types and helpers for the trigger distribution datapath.
// Contents: t_trig_ts timestamp struct, c_TS_WIDTH, f_ts_normalise(), f_ts_less().
// No ports; imported by trig_rx_sched_fifo and trig_rx_delay_sched.
package trig_dist_pkg;

  localparam int c_TS_WIDTH = 80;

  typedef struct packed {
    logic [39:0] tai;
    logic [27:0] cycles;
    logic [11:0] frac;
  } t_trig_ts;

  // Fold one second's worth of cycles into the seconds field. The caller
  // guarantees cycles < 2*clk_freq, so a single conditional subtract is enough.
  function automatic t_trig_ts f_ts_normalise(input logic [39:0] tai,
                                              input logic [28:0] cycles,
                                              input logic [11:0] frac,
                                              input logic [28:0] clk_freq);
    t_trig_ts r;
    r.frac = frac;
    if (cycles >= clk_freq) begin
      r.cycles = 28'(cycles - clk_freq);
      r.tai    = tai + 40'd1;
    end else begin
      r.cycles = cycles[27:0];
      r.tai    = tai;
    end
    return r;
  endfunction

  // Strict lexicographic a < b over {tai, cycles, frac}.
  function automatic logic f_ts_less(input t_trig_ts a, input t_trig_ts b);
    if (a.tai != b.tai)       return a.tai < b.tai;
    if (a.cycles != b.cycles) return a.cycles < b.cycles;
    return a.frac < b.frac;
  endfunction

endpackage

// File: rtl/trig_rx_sched_fifo.sv
// Synchronous first-word-fall-through FIFO of t_trig_ts.
// Ports: push_i/data_i write side, pop_i/data_o read side, full_o/empty_o status.
// A push while full is accepted only if a pop happens in the same cycle; data_o reads 0 when empty.
module trig_rx_sched_fifo
  import trig_dist_pkg::*;
#(
  parameter int g_depth = 8
) (
  input  logic     clk_sys_i,
  input  logic     rst_n_i,
  input  logic     push_i,
  input  t_trig_ts data_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output t_trig_ts data_o
);

  localparam int c_AW = $clog2(g_depth);

  logic [c_TS_WIDTH-1:0] mem [g_depth];
  logic [c_AW:0]         wr_ptr;
  logic [c_AW:0]         rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[c_AW] != rd_ptr[c_AW]) &&
                   (wr_ptr[c_AW-1:0] == rd_ptr[c_AW-1:0]);

  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the empty gating below keeps the output at 0.
  always_ff @(posedge clk_sys_i) begin
    if (wr_en) mem[wr_ptr[c_AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : t_trig_ts'(mem[rd_ptr[c_AW-1:0]]);

endmodule

// File: rtl/trig_rx_delay_sched.sv
// Trigger-receive scheduler: ID filter, coarse/fine delay add, TAI normalise, FWFT output queue.
// Ports: rx_* decoded trigger in, cfg_* register config, tm_* WR time, out_* FD timestamp, cnt_* stats.
// Latency rx->out_valid 3 cycles when idle; input never back-pressured (full FIFO drops and counts).
// Optional macro TRIG_RX_LATE_CHECK_EN: drop events closer than g_min_lead cycles to current WR time.
module trig_rx_delay_sched
  import trig_dist_pkg::*;
#(
  parameter int g_id_width   = 16,
  parameter int g_clk_freq   = 125000000,
  parameter int g_fifo_depth = 8,
  parameter int g_min_lead   = 1250
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_n_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  input  logic [g_id_width-1:0] rx_id_i,
  input  logic [39:0]           rx_tai_i,
  input  logic [27:0]           rx_cycles_i,
  input  logic [11:0]           rx_frac_i,
  input  logic                  cfg_enable_i,
  input  logic [g_id_width-1:0] cfg_id_i,
  input  logic [27:0]           cfg_delay_c_i,
  input  logic [11:0]           cfg_delay_f_i,
  input  logic                  cfg_rst_cnt_i,
  input  logic [39:0]           tm_tai_i,
  input  logic [27:0]           tm_cycles_i,
  input  logic                  tm_valid_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [39:0]           out_tai_o,
  output logic [27:0]           out_cycles_o,
  output logic [11:0]           out_frac_o,
  output logic [31:0]           cnt_rx_o,
  output logic [31:0]           cnt_sched_o,
  output logic [31:0]           cnt_late_o,
  output logic [31:0]           cnt_ovf_o
);

  localparam logic [28:0] c_CLK    = 29'(g_clk_freq);
  localparam logic [27:0] c_CLK28  = 28'(g_clk_freq);
  localparam logic [27:0] c_DC_MAX = 28'(g_clk_freq - 1);

  // S0: captured message plus the config that applies to it
  logic        s0_vld;
  t_trig_ts    s0_ts;
  logic [27:0] s0_dc;
  logic [11:0] s0_df;
  // S1: raw sums, cycles not yet normalised
  logic        s1_vld;
  logic [39:0] s1_tai;
  logic [28:0] s1_c;
  logic [11:0] s1_frac;
  // S2 (combinational into the FIFO)
  t_trig_ts    s2_ts;
  logic        s2_late;

  logic        capture;
  logic [12:0] f_sum;
  logic [28:0] c_sum;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  t_trig_ts    fifo_dout;
  logic        inc_sched;
  logic        inc_ovf;

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) rx_ready_o <= 1'b0;
    else          rx_ready_o <= 1'b1;
  end

  assign capture = rx_ready_o & rx_valid_i & cfg_enable_i & (rx_id_i == cfg_id_i);

  // Delay is clamped below one second so S2's single subtract always normalises.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      s0_vld <= 1'b0;
      s0_ts  <= '0;
      s0_dc  <= '0;
      s0_df  <= '0;
    end else begin
      s0_vld <= capture;
      if (capture) begin
        s0_ts.tai    <= rx_tai_i;
        s0_ts.cycles <= rx_cycles_i;
        s0_ts.frac   <= rx_frac_i;
        s0_dc        <= (cfg_delay_c_i >= c_CLK28) ? c_DC_MAX : cfg_delay_c_i;
        s0_df        <= cfg_delay_f_i;
      end
    end
  end

  assign f_sum = {1'b0, s0_ts.frac} + {1'b0, s0_df};
  assign c_sum = {1'b0, s0_ts.cycles} + {1'b0, s0_dc} + {28'd0, f_sum[12]};

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      s1_vld  <= 1'b0;
      s1_tai  <= '0;
      s1_c    <= '0;
      s1_frac <= '0;
    end else begin
      s1_vld  <= s0_vld;
      s1_tai  <= s0_ts.tai;
      s1_c    <= c_sum;
      s1_frac <= f_sum[11:0];
    end
  end

  assign s2_ts = f_ts_normalise(s1_tai, s1_c, s1_frac, c_CLK);

`ifdef TRIG_RX_LATE_CHECK_EN
  // Earliest acceptable event time: now + lead, normalised like the event itself.
  t_trig_ts min_ts;
  assign min_ts  = f_ts_normalise(tm_tai_i, {1'b0, tm_cycles_i} + 29'(g_min_lead), 12'd0, c_CLK);
  assign s2_late = ~tm_valid_i | f_ts_less(s2_ts, min_ts);
`else
  logic unused_tm;
  assign unused_tm = ^{tm_tai_i, tm_cycles_i, tm_valid_i};
  assign s2_late   = 1'b0;
`endif

  assign push = s1_vld & ~s2_late;
  assign pop  = out_valid_o & out_ready_i;

  trig_rx_sched_fifo #(
    .g_depth (g_fifo_depth)
  ) u_fifo (
    .clk_sys_i (clk_sys_i),
    .rst_n_i   (rst_n_i),
    .push_i    (push),
    .data_i    (s2_ts),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .data_o    (fifo_dout)
  );

  assign out_valid_o  = ~fifo_empty;
  assign out_tai_o    = fifo_dout.tai;
  assign out_cycles_o = fifo_dout.cycles;
  assign out_frac_o   = fifo_dout.frac;

  // A pop frees the slot in the same cycle, so push-while-full-and-popping is accepted.
  assign inc_sched = push & (~fifo_full | pop);
  assign inc_ovf   = push & fifo_full & ~pop;

  // Counter clear has priority over any increment in the same cycle.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i || cfg_rst_cnt_i) begin
      cnt_rx_o    <= '0;
      cnt_sched_o <= '0;
      cnt_ovf_o   <= '0;
    end else begin
      cnt_rx_o    <= cnt_rx_o    + {31'd0, capture};
      cnt_sched_o <= cnt_sched_o + {31'd0, inc_sched};
      cnt_ovf_o   <= cnt_ovf_o   + {31'd0, inc_ovf};
    end
  end

`ifdef TRIG_RX_LATE_CHECK_EN
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i || cfg_rst_cnt_i) cnt_late_o <= '0;
    else                           cnt_late_o <= cnt_late_o + {31'd0, s1_vld & s2_late};
  end
`else
  assign cnt_late_o = '0;
`endif

endmodule

// File: tb/tb_trig_rx_delay_sched.sv
module tb_trig_rx_delay_sched;

  localparam longint unsigned CLK   = 125000000;
  localparam int              DEPTH = 8;
`ifdef TRIG_RX_LATE_CHECK_EN
  localparam longint unsigned LEAD  = 1250;
`endif

  logic        clk;
  logic        rst_n, rx_valid, rx_ready, cfg_enable, cfg_rst_cnt, tm_valid, out_valid, out_ready;
  logic [15:0] rx_id, cfg_id;
  logic [39:0] rx_tai, tm_tai, out_tai;
  logic [27:0] rx_cyc, cfg_dc, tm_cyc, out_cyc;
  logic [11:0] rx_frac, cfg_df, out_frac;
  logic [31:0] cnt_rx, cnt_sched, cnt_late, cnt_ovf;

  trig_rx_delay_sched dut (
    .clk_sys_i(clk), .rst_n_i(rst_n), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .rx_id_i(rx_id), .rx_tai_i(rx_tai), .rx_cycles_i(rx_cyc), .rx_frac_i(rx_frac),
    .cfg_enable_i(cfg_enable), .cfg_id_i(cfg_id), .cfg_delay_c_i(cfg_dc), .cfg_delay_f_i(cfg_df),
    .cfg_rst_cnt_i(cfg_rst_cnt), .tm_tai_i(tm_tai), .tm_cycles_i(tm_cyc), .tm_valid_i(tm_valid),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_tai_o(out_tai), .out_cycles_o(out_cyc),
    .out_frac_o(out_frac), .cnt_rx_o(cnt_rx), .cnt_sched_o(cnt_sched), .cnt_late_o(cnt_late),
    .cnt_ovf_o(cnt_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [39:0] tai;
    logic [27:0] cyc;
    logic [11:0] frac;
  } ev_t;

  // Whole delay arithmetic done in units of 1/4096 cycle within the second.
  function automatic ev_t ref_delay(input logic [39:0] tai, input logic [27:0] cyc,
                                    input logic [11:0] frac, input logic [27:0] dc,
                                    input logic [11:0] df);
    longint unsigned dcl, sub, per_s;
    ev_t r;
    dcl = 64'(dc);
    if (dcl >= CLK) dcl = CLK - 1;
    sub   = 64'(cyc) * 4096 + 64'(frac) + dcl * 4096 + 64'(df);
    per_s = CLK * 4096;
    r.tai  = tai + 40'(sub / per_s);
    r.cyc  = 28'((sub % per_s) / 4096);
    r.frac = 12'(sub % 4096);
    return r;
  endfunction

`ifdef TRIG_RX_LATE_CHECK_EN
  function automatic bit ref_late(input ev_t e, input logic tv, input logic [39:0] tt,
                                  input logic [27:0] tc);
    longint unsigned lc;
    logic [39:0] lt;
    lc = 64'(tc) + LEAD;
    lt = tt + 40'(lc / CLK);
    lc = lc % CLK;
    if (!tv) return 1'b1;
    if (e.tai != lt) return e.tai < lt;
    return 64'(e.cyc) < lc;
  endfunction
`endif

  typedef struct packed {
    logic        rst_n, rx_valid;
    logic [15:0] id;
    logic [39:0] tai;
    logic [27:0] cyc;
    logic [11:0] frac;
    logic        en;
    logic [15:0] cid;
    logic [27:0] dc;
    logic [11:0] df;
    logic        rst_cnt;
    logic [39:0] tmt;
    logic [27:0] tmc;
    logic        tmv, ordy;
  } smp_t;

  smp_t smp;
  bit   smp_v = 1'b0;

  always @(posedge clk) begin
    smp   <= {rst_n, rx_valid, rx_id, rx_tai, rx_cyc, rx_frac, cfg_enable, cfg_id, cfg_dc,
              cfg_df, cfg_rst_cnt, tm_tai, tm_cyc, tm_valid, out_ready};
    smp_v <= 1'b1;
  end

  ev_t         mq[$];
  ev_t         p_old, p_new;
  bit          pv_old = 0, pv_new = 0, m_ready = 0;
  logic [31:0] m_rx = 0, m_sched = 0, m_ovf = 0, m_late = 0;

  // Model advances on the inputs seen at the last rising edge, then compares.
  initial begin
    forever begin
      bit pop, acc, late, cap;
      logic [31:0] d_rx, d_sc, d_ov, d_lt;
      @(negedge clk);
      if (smp_v) begin
        if (!smp.rst_n) begin
          mq.delete();
          pv_old = 0; pv_new = 0; m_ready = 0;
          m_rx = 0; m_sched = 0; m_ovf = 0; m_late = 0;
        end else begin
          d_rx = 0; d_sc = 0; d_ov = 0; d_lt = 0;
          pop  = (mq.size() > 0) && smp.ordy;
          late = 1'b0;
`ifdef TRIG_RX_LATE_CHECK_EN
          if (pv_old) late = ref_late(p_old, smp.tmv, smp.tmt, smp.tmc);
`endif
          if (pv_old && late) d_lt = 1;
          acc = pv_old && !late && ((mq.size() < DEPTH) || pop);
          if (pv_old && !late && !acc) d_ov = 1;
          if (pop) void'(mq.pop_front());
          if (acc) begin
            mq.push_back(p_old);
            d_sc = 1;
          end
          cap    = m_ready && smp.rx_valid && smp.en && (smp.id == smp.cid);
          p_old  = p_new;
          pv_old = pv_new;
          pv_new = cap;
          if (cap) begin
            p_new = ref_delay(smp.tai, smp.cyc, smp.frac, smp.dc, smp.df);
            d_rx  = 1;
          end
          m_ready = 1;
          if (smp.rst_cnt) begin
            m_rx = 0; m_sched = 0; m_ovf = 0; m_late = 0;
          end else begin
            m_rx += d_rx; m_sched += d_sc; m_ovf += d_ov; m_late += d_lt;
          end
        end
        chk("m_rx_ready", rx_ready, m_ready);
        chk("m_out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) chk("m_out_ts", {out_tai, out_cyc, out_frac}, mq[0]);
        chk("m_cnt_rx", cnt_rx, m_rx);
        chk("m_cnt_sched", cnt_sched, m_sched);
        chk("m_cnt_ovf", cnt_ovf, m_ovf);
        chk("m_cnt_late", cnt_late, m_late);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] id, input logic [39:0] tai, input logic [27:0] cyc,
                      input logic [11:0] frac);
    @(negedge clk);
    rx_valid = 1; rx_id = id; rx_tai = tai; rx_cyc = cyc; rx_frac = frac;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic pop_one();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  typedef struct {
    logic [15:0] id;
    logic [39:0] tai;
    logic [27:0] cyc;
    logic [11:0] frac;
    logic [27:0] dc;
    logic [11:0] df;
    bit          exp_v;
    logic [39:0] e_tai;
    logic [27:0] e_cyc;
    logic [11:0] e_frac;
  } vec_t;

  vec_t vecs[6];
  int   e_rx, e_sched;

  initial begin
    rst_n = 0; rx_valid = 0; rx_id = 0; rx_tai = 0; rx_cyc = 0; rx_frac = 0;
    cfg_enable = 1; cfg_id = 16'd11; cfg_dc = 0; cfg_df = 0; cfg_rst_cnt = 0;
    tm_tai = 0; tm_cyc = 0; tm_valid = 1; out_ready = 0;

    vecs[0] = '{16'd11, 40'd5, 28'd1000, 12'd100, 28'd2000, 12'd0, 1'b1, 40'd5, 28'd3000, 12'd100};
    vecs[1] = '{16'd11, 40'd7, 28'd124999990, 12'd200, 28'd10, 12'd4000, 1'b1, 40'd8, 28'd1, 12'd104};
    vecs[2] = '{16'd12, 40'd5, 28'd1000, 12'd100, 28'd2000, 12'd0, 1'b0, 40'd0, 28'd0, 12'd0};
    vecs[3] = '{16'd11, 40'd3, 28'd0, 12'd0, 28'd200000000, 12'd0, 1'b1, 40'd3, 28'd124999999, 12'd0};
    vecs[4] = '{16'd11, 40'hFF_FFFF_FFFF, 28'd124999000, 12'd0, 28'd5000, 12'd0, 1'b1, 40'd0, 28'd4000, 12'd0};
    vecs[5] = '{16'd11, 40'd9, 28'd0, 12'd4095, 28'd0, 12'd1, 1'b1, 40'd9, 28'd1, 12'd0};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_out_ts", {out_tai, out_cyc, out_frac}, 0);
    chk("rst_cnt_rx", cnt_rx, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rx_ready_up", rx_ready, 1);

    // table-driven single events: latency, delay arithmetic, filter, clamp, wrap
    e_rx = 0; e_sched = 0;
    foreach (vecs[i]) begin
      cfg_dc = vecs[i].dc;
      cfg_df = vecs[i].df;
      send(vecs[i].id, vecs[i].tai, vecs[i].cyc, vecs[i].frac);
      @(negedge clk);
      chk("vec_not_early", out_valid, 0);
      @(negedge clk);
      chk("vec_valid", out_valid, vecs[i].exp_v);
      if (vecs[i].exp_v) begin
        e_rx++; e_sched++;
        chk("vec_ts", {out_tai, out_cyc, out_frac}, {vecs[i].e_tai, vecs[i].e_cyc, vecs[i].e_frac});
      end
      chk("vec_cnt_rx", cnt_rx, 32'(e_rx));
      chk("vec_cnt_sched", cnt_sched, 32'(e_sched));
      if (vecs[i].exp_v) pop_one();
    end

    // enable off: matching ID ignored
    cfg_enable = 0; cfg_dc = 0; cfg_df = 0;
    send(16'd11, 40'd1, 28'd5, 12'd0);
    repeat (3) @(negedge clk);
    chk("dis_valid", out_valid, 0);
    chk("dis_cnt_rx", cnt_rx, 32'(e_rx));
    cfg_enable = 1;

    // overflow: 10 back-to-back with ready low -> 8 queued, 2 dropped
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1; rx_id = 16'd11; rx_tai = 40'd20; rx_cyc = 28'(i * 10); rx_frac = 0;
      @(negedge clk);
    end
    rx_valid = 0;
    repeat (3) @(negedge clk);
    chk("ovf_cnt_ovf", cnt_ovf, 2);
    chk("ovf_cnt_sched", cnt_sched, 32'(e_sched + 8));
    chk("ovf_cnt_rx", cnt_rx, 32'(e_rx + 10));
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_valid", out_valid, 1);
      chk("ovf_drain_cyc", out_cyc, 28'(i * 10));
      @(negedge clk);
    end
    chk("ovf_drained", out_valid, 0);
    out_ready = 0;

    // counter clear in the same cycle as the FIFO push
    send(16'd11, 40'd30, 28'd0, 12'd0);
    @(negedge clk);
    cfg_rst_cnt = 1;
    @(negedge clk);
    cfg_rst_cnt = 0;
    chk("rstcnt_valid", out_valid, 1);
    chk("rstcnt_rx", cnt_rx, 0);
    chk("rstcnt_sched", cnt_sched, 0);
    chk("rstcnt_ovf", cnt_ovf, 0);
    pop_one();

`ifdef TRIG_RX_LATE_CHECK_EN
    tm_tai = 40'd100; tm_cyc = 0; tm_valid = 1;
    send(16'd11, 40'd99, 28'd0, 12'd0);
    repeat (2) @(negedge clk);
    chk("late_past", out_valid, 0);
    chk("late_cnt1", cnt_late, 1);
    send(16'd11, 40'd100, 28'd1249, 12'd0);
    repeat (2) @(negedge clk);
    chk("late_edge", out_valid, 0);
    send(16'd11, 40'd100, 28'd1250, 12'd0);
    repeat (2) @(negedge clk);
    chk("late_exact_ok", out_valid, 1);
    pop_one();
    send(16'd11, 40'd100, 28'd2000, 12'd0);
    repeat (2) @(negedge clk);
    chk("late_ok", out_valid, 1);
    pop_one();
    tm_valid = 0;
    send(16'd11, 40'd100, 28'd2000, 12'd0);
    repeat (2) @(negedge clk);
    chk("late_tm_invalid", out_valid, 0);
    chk("late_cnt3", cnt_late, 3);
    tm_valid = 1; tm_tai = 0;
`else
    chk("late_tied", cnt_late, 0);
`endif

    // reset in the middle of a burst
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1; rx_id = 16'd11; rx_tai = 40'd40; rx_cyc = 28'(i); rx_frac = 0;
      @(negedge clk);
    end
    rst_n = 0;
    @(negedge clk);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", rx_ready, 0);
    chk("mrst_ts", {out_tai, out_cyc, out_frac}, 0);
    chk("mrst_cnt_rx", cnt_rx, 0);
    rst_n = 1; rx_valid = 0;
    repeat (3) @(negedge clk);
    chk("mrst_flushed", out_valid, 0);

    // randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] t;
      t          = {$urandom, $urandom};
      rx_valid   = ($urandom_range(0, 99) < 60);
      rx_id      = ($urandom_range(0, 9) == 0) ? 16'd12 : 16'd11;
      rx_tai     = t[39:0];
      rx_cyc     = 28'($urandom_range(0, 124999999));
      rx_frac    = 12'($urandom);
      cfg_enable = ($urandom_range(0, 99) < 95);
      if ($urandom_range(0, 49) == 0) begin
        cfg_dc = 28'($urandom_range(0, 130000000));
        cfg_df = 12'($urandom);
      end
      out_ready   = ($urandom_range(0, 99) < 60);
      cfg_rst_cnt = ($urandom_range(0, 199) == 0);
      tm_valid    = ($urandom_range(0, 19) != 0);
      t           = {$urandom, $urandom};
      tm_tai      = t[39:0];
      tm_cyc      = 28'($urandom_range(0, 124999999));
      @(negedge clk);
    end
    rx_valid = 0; cfg_rst_cnt = 0; out_ready = 1;
    repeat (20) @(negedge clk);
    chk("final_drained", out_valid, 0);

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
